// File: rtl/nx_ctrl_arbiter.sv
// Round-robin arbiter sharing the nx_node_store control port between REQUESTERS clients.
// Optional locked read-modify-write sequences are built when NX_CTRL_ARB_LOCK_EN is defined.
module nx_ctrl_arbiter #(
    parameter  int unsigned CTRL_WIDTH = 12,
    parameter  int unsigned MAX_CTRL   = 512,
    parameter  int unsigned REQUESTERS = 2,
    localparam int unsigned ADDR_W     = $clog2(MAX_CTRL)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [REQUESTERS-1:0][ADDR_W-1:0]      req_addr_i,
    input  logic [REQUESTERS-1:0][CTRL_WIDTH-1:0]  req_wr_data_i,
    input  logic [REQUESTERS-1:0]                  req_wr_en_i,
    input  logic [REQUESTERS-1:0]                  req_rd_en_i,
    input  logic [REQUESTERS-1:0]                  req_lock_i,
    output logic [REQUESTERS-1:0]                  req_gnt_o,
    output logic [REQUESTERS-1:0]                  req_rd_valid_o,
    output logic [CTRL_WIDTH-1:0]                  req_rd_data_o,
    output logic [ADDR_W-1:0]                      ctrl_addr_o,
    output logic [CTRL_WIDTH-1:0]                  ctrl_wr_data_o,
    output logic                                   ctrl_wr_en_o,
    output logic                                   ctrl_rd_en_o,
    input  logic [CTRL_WIDTH-1:0]                  ctrl_rd_data_i
);

    localparam int unsigned PTR_W = $clog2(REQUESTERS);

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [REQUESTERS-1:0] rd_owner_q, rd_owner_d;
    logic [REQUESTERS-1:0] req_act_c;
    logic [REQUESTERS-1:0] elig_c;
    logic [REQUESTERS-1:0] gnt_c;
    logic [PTR_W-1:0]      gnt_idx_c;
    logic [PTR_W-1:0]      cand_c;
    logic                  gnt_any_c;

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
        return PTR_W'((32'(idx) + 32'd1) % REQUESTERS);
    endfunction

    assign req_act_c = req_wr_en_i | req_rd_en_i;

`ifdef NX_CTRL_ARB_LOCK_EN
    typedef enum logic {
        LK_FREE = 1'b0,
        LK_HELD = 1'b1
    } lock_state_e;

    lock_state_e           lk_state_q, lk_state_d;
    logic [PTR_W-1:0]      lk_owner_q, lk_owner_d;
    logic [REQUESTERS-1:0] lk_mask_c;

    // While a lock is held only its owner may be granted
    always_comb begin
        lk_mask_c = '1;
        if (lk_state_q == LK_HELD) begin
            lk_mask_c             = '0;
            lk_mask_c[lk_owner_q] = 1'b1;
        end
    end

    assign elig_c = req_act_c & lk_mask_c;
`else
    logic unused_lock_c;

    assign unused_lock_c = ^req_lock_i;
    assign elig_c        = req_act_c;
`endif

    // First eligible client at or after ptr, wrapping; nothing is granted in reset
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        cand_c    = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            cand_c = PTR_W'((32'(ptr_q) + 32'(k)) % REQUESTERS);
            if (!gnt_any_c && !rst_i && elig_c[cand_c]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = cand_c;
            end
        end
        if (gnt_any_c) begin
            gnt_c[gnt_idx_c] = 1'b1;
        end
    end

    // A write wins over a simultaneous read from the same client
    always_comb begin
        ctrl_addr_o    = '0;
        ctrl_wr_data_o = '0;
        ctrl_wr_en_o   = 1'b0;
        ctrl_rd_en_o   = 1'b0;
        if (gnt_any_c) begin
            ctrl_addr_o    = req_addr_i[gnt_idx_c];
            ctrl_wr_data_o = req_wr_data_i[gnt_idx_c];
            ctrl_wr_en_o   = req_wr_en_i[gnt_idx_c];
            ctrl_rd_en_o   = req_rd_en_i[gnt_idx_c] & ~req_wr_en_i[gnt_idx_c];
        end
    end

    assign req_gnt_o      = gnt_c;
    assign req_rd_valid_o = rst_i ? '0 : rd_owner_q;
    assign req_rd_data_o  = ctrl_rd_data_i;

    always_comb begin
        ptr_d      = ptr_q;
        rd_owner_d = ctrl_rd_en_o ? gnt_c : '0;
`ifdef NX_CTRL_ARB_LOCK_EN
        lk_state_d = lk_state_q;
        lk_owner_d = lk_owner_q;
        // The pointer only moves past a client once it has given up the port
        case (lk_state_q)
            LK_FREE: begin
                if (gnt_any_c) begin
                    if (req_lock_i[gnt_idx_c]) begin
                        lk_state_d = LK_HELD;
                        lk_owner_d = gnt_idx_c;
                    end else begin
                        ptr_d = ptr_after(gnt_idx_c);
                    end
                end
            end
            LK_HELD: begin
                if (!req_lock_i[lk_owner_q]) begin
                    lk_state_d = LK_FREE;
                    ptr_d      = ptr_after(lk_owner_q);
                end
            end
        endcase
`else
        if (gnt_any_c) begin
            ptr_d = ptr_after(gnt_idx_c);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            rd_owner_q <= '0;
`ifdef NX_CTRL_ARB_LOCK_EN
            lk_state_q <= LK_FREE;
            lk_owner_q <= '0;
`endif
        end else begin
            ptr_q      <= ptr_d;
            rd_owner_q <= rd_owner_d;
`ifdef NX_CTRL_ARB_LOCK_EN
            lk_state_q <= lk_state_d;
            lk_owner_q <= lk_owner_d;
`endif
        end
    end

endmodule

// File: tb/tb_nx_ctrl_arbiter.sv
// Self-checking bench for nx_ctrl_arbiter: directed cases plus randomized traffic against
// a behavioural arbiter/store model. Lock cases run when NX_CTRL_ARB_LOCK_EN is defined.
module tb_nx_ctrl_arbiter;

    localparam int unsigned CW   = 12;
    localparam int unsigned MAXC = 512;
    localparam int unsigned N    = 3;
    localparam int unsigned AW   = $clog2(MAXC);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [N-1:0][AW-1:0]  req_addr;
    logic [N-1:0][CW-1:0]  req_wr_data;
    logic [N-1:0]          req_wr_en, req_rd_en, req_lock;
    logic [N-1:0]          req_gnt, req_rd_valid;
    logic [CW-1:0]         req_rd_data;
    logic [AW-1:0]         ctrl_addr;
    logic [CW-1:0]         ctrl_wr_data, ctrl_rd_data;
    logic                  ctrl_wr_en, ctrl_rd_en;

    nx_ctrl_arbiter #(
        .CTRL_WIDTH (CW),
        .MAX_CTRL   (MAXC),
        .REQUESTERS (N)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_addr_i     (req_addr),
        .req_wr_data_i  (req_wr_data),
        .req_wr_en_i    (req_wr_en),
        .req_rd_en_i    (req_rd_en),
        .req_lock_i     (req_lock),
        .req_gnt_o      (req_gnt),
        .req_rd_valid_o (req_rd_valid),
        .req_rd_data_o  (req_rd_data),
        .ctrl_addr_o    (ctrl_addr),
        .ctrl_wr_data_o (ctrl_wr_data),
        .ctrl_wr_en_o   (ctrl_wr_en),
        .ctrl_rd_en_o   (ctrl_rd_en),
        .ctrl_rd_data_i (ctrl_rd_data)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pointer, lock owner (-1 none), pending read owner (-1 none)
    int            m_ptr, m_lock, m_rdo;
    logic [CW-1:0] m_rd_data;
    logic [CW-1:0] model_mem [MAXC];
    logic [CW-1:0] store_mem [MAXC];
    logic [CW-1:0] store_rd_next;
    logic [N-1:0]  pend;
    logic [N-1:0]  wrap_seq [4];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_grant();
        if (rst) return -1;
        if (m_lock >= 0) return (req_wr_en[m_lock] || req_rd_en[m_lock]) ? m_lock : -1;
        for (int k = 0; k < int'(N); k++) begin
            int c;
            c = (m_ptr + k) % int'(N);
            if (req_wr_en[c] || req_rd_en[c]) return c;
        end
        return -1;
    endfunction

    task automatic sample_model(output int g);
        logic [N-1:0]  eg, ev;
        logic [AW-1:0] ea;
        logic [CW-1:0] ed;
        logic          ew, er;
        g  = exp_grant();
        eg = '0; ev = '0; ea = '0; ed = '0; ew = 1'b0; er = 1'b0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ea    = req_addr[g];
            ed    = req_wr_data[g];
            ew    = req_wr_en[g];
            er    = req_rd_en[g] && !req_wr_en[g];
        end
        if (!rst && m_rdo >= 0) ev[m_rdo] = 1'b1;
        chk_eq("gnt", 32'(req_gnt), 32'(eg));
        chk_eq("ctrl_addr", 32'(ctrl_addr), 32'(ea));
        chk_eq("ctrl_wr_data", 32'(ctrl_wr_data), 32'(ed));
        chk_eq("ctrl_wr_en", 32'(ctrl_wr_en), 32'(ew));
        chk_eq("ctrl_rd_en", 32'(ctrl_rd_en), 32'(er));
        chk_eq("rd_valid", 32'(req_rd_valid), 32'(ev));
        if (ev != '0) chk_eq("rd_data", 32'(req_rd_data), 32'(m_rd_data));
    endtask

    task automatic tick(input int g);
        // Store stand-in responds to whatever the arbiter actually forwarded
        store_rd_next = ctrl_rd_en ? store_mem[ctrl_addr] : CW'($urandom);
        if (ctrl_wr_en) store_mem[ctrl_addr] = ctrl_wr_data;
        if (rst) begin
            m_ptr = 0; m_lock = -1; m_rdo = -1;
        end else begin
            m_rdo = -1;
            if (g >= 0) begin
                if (req_wr_en[g]) model_mem[req_addr[g]] = req_wr_data[g];
                else if (req_rd_en[g]) begin
                    m_rdo     = g;
                    m_rd_data = model_mem[req_addr[g]];
                end
            end
`ifdef NX_CTRL_ARB_LOCK_EN
            if (m_lock >= 0) begin
                if (!req_lock[m_lock]) begin
                    m_ptr  = (m_lock + 1) % int'(N);
                    m_lock = -1;
                end
            end else if (g >= 0) begin
                if (req_lock[g]) m_lock = g;
                else m_ptr = (g + 1) % int'(N);
            end
`else
            if (g >= 0) m_ptr = (g + 1) % int'(N);
`endif
        end
        @(posedge clk);
        #1;
        ctrl_rd_data = store_rd_next;
    endtask

    task automatic run_cycle(output int g);
        sample_model(g);
        tick(g);
    endtask

    task automatic clear_reqs();
        req_addr = '0; req_wr_data = '0; req_wr_en = '0; req_rd_en = '0; req_lock = '0;
    endtask

    task automatic do_reset();
        int g;
        clear_reqs();
        rst = 1'b1;
        #3;
        run_cycle(g);
        rst = 1'b0;
    endtask

    initial begin
        int g;
        for (int i = 0; i < int'(MAXC); i++) begin
            model_mem[i] = CW'(i * 7 + 3);
            store_mem[i] = CW'(i * 7 + 3);
        end
        m_ptr = 0; m_lock = -1; m_rdo = -1; m_rd_data = '0;
        wrap_seq[0] = 3'b100; wrap_seq[1] = 3'b001; wrap_seq[2] = 3'b010; wrap_seq[3] = 3'b100;
        clear_reqs();
        rst = 1'b1;
        ctrl_rd_data = '0;
        @(posedge clk);
        #1;

        // Reset values, with requests present
        req_rd_en = '1;
        #3;
        chk_eq("rst_gnt", 32'(req_gnt), 32'h0);
        chk_eq("rst_rd_valid", 32'(req_rd_valid), 32'h0);
        chk_eq("rst_ctrl_rd_en", 32'(ctrl_rd_en), 32'h0);
        chk_eq("rst_ctrl_addr", 32'(ctrl_addr), 32'h0);
        run_cycle(g);

        // Single client write then read back
        do_reset();
        req_wr_en[0] = 1'b1; req_addr[0] = AW'(5); req_wr_data[0] = 12'hABC;
        #3;
        chk_eq("t1_gnt_wr", 32'(req_gnt), 32'h1);
        chk_eq("t1_wr_en", 32'(ctrl_wr_en), 32'h1);
        chk_eq("t1_wr_data", 32'(ctrl_wr_data), 32'hABC);
        run_cycle(g);
        req_wr_en[0] = 1'b0; req_rd_en[0] = 1'b1;
        #3;
        chk_eq("t1_gnt_rd", 32'(req_gnt), 32'h1);
        chk_eq("t1_rd_en", 32'(ctrl_rd_en), 32'h1);
        chk_eq("t1_addr", 32'(ctrl_addr), 32'h5);
        run_cycle(g);
        clear_reqs();
        #3;
        chk_eq("t1_rd_valid", 32'(req_rd_valid), 32'h1);
        chk_eq("t1_rd_data", 32'(req_rd_data), 32'hABC);
        run_cycle(g);

        // Two clients reading continuously: alternate grants, pipelined returns
        do_reset();
        req_rd_en[0] = 1'b1; req_addr[0] = AW'(1);
        req_rd_en[1] = 1'b1; req_addr[1] = AW'(2);
        for (int i = 0; i < 6; i++) begin
            #3;
            chk_eq("t2_gnt", 32'(req_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk_eq("t2_rd_valid", 32'(req_rd_valid), (i == 0) ? 32'h0 : ((i % 2 == 1) ? 32'h1 : 32'h2));
            run_cycle(g);
        end

        // Pointer wrap with three requesters starting from ptr=2
        do_reset();
        req_rd_en[1] = 1'b1;
        #3;
        run_cycle(g);
        req_rd_en = '1;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk_eq("t3_wrap_gnt", 32'(req_gnt), 32'(wrap_seq[i]));
            run_cycle(g);
        end

        // Write and read together: write wins, no read return
        do_reset();
        req_wr_en[1] = 1'b1; req_rd_en[1] = 1'b1; req_addr[1] = AW'(9); req_wr_data[1] = 12'h123;
        #3;
        chk_eq("t4_gnt", 32'(req_gnt), 32'h2);
        chk_eq("t4_wr_en", 32'(ctrl_wr_en), 32'h1);
        chk_eq("t4_rd_en", 32'(ctrl_rd_en), 32'h0);
        run_cycle(g);
        clear_reqs();
        #3;
        chk_eq("t4_no_valid", 32'(req_rd_valid), 32'h0);
        run_cycle(g);

        // Reset right after a granted read
        do_reset();
        req_rd_en[1] = 1'b1;
        #3;
        run_cycle(g);
        req_rd_en = '0; req_rd_en[0] = 1'b1;
        #3;
        chk_eq("t5_gnt_pre", 32'(req_gnt), 32'h1);
        run_cycle(g);
        rst = 1'b1;
        req_rd_en = '1;
        #3;
        chk_eq("t5_rst_valid", 32'(req_rd_valid), 32'h0);
        chk_eq("t5_rst_gnt", 32'(req_gnt), 32'h0);
        run_cycle(g);
        rst = 1'b0;
        #3;
        chk_eq("t5_ptr_zero", 32'(req_gnt), 32'h1);
        chk_eq("t5_post_valid", 32'(req_rd_valid), 32'h0);
        run_cycle(g);

`ifdef NX_CTRL_ARB_LOCK_EN
        // Locked read-modify-write by client 0 blocks client 1
        do_reset();
        req_rd_en[0] = 1'b1; req_addr[0] = AW'(7); req_lock[0] = 1'b1;
        req_rd_en[1] = 1'b1; req_addr[1] = AW'(3);
        #3;
        chk_eq("lk_gnt0", 32'(req_gnt), 32'h1);
        run_cycle(g);
        req_rd_en[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #3;
            chk_eq("lk_blocked", 32'(req_gnt), 32'h0);
            run_cycle(g);
        end
        req_wr_en[0] = 1'b1; req_wr_data[0] = 12'h5A5; req_lock[0] = 1'b0;
        #3;
        chk_eq("lk_unlock_wr", 32'(req_gnt), 32'h1);
        run_cycle(g);
        req_wr_en[0] = 1'b0;
        #3;
        chk_eq("lk_release", 32'(req_gnt), 32'h2);
        run_cycle(g);
`endif

        // Randomized traffic against the model
        do_reset();
        pend = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst = ($urandom % 64 == 0);
            for (int i = 0; i < int'(N); i++) begin
                if (!pend[i]) begin
                    if ($urandom % 2 == 1) begin
                        pend[i]        = 1'b1;
                        req_addr[i]    = AW'($urandom % 16);
                        req_wr_data[i] = CW'($urandom);
                        req_wr_en[i]   = 1'($urandom);
                        req_rd_en[i]   = 1'($urandom);
                        if (!req_wr_en[i] && !req_rd_en[i]) req_rd_en[i] = 1'b1;
                    end else begin
                        req_wr_en[i] = 1'b0;
                        req_rd_en[i] = 1'b0;
                    end
                    req_lock[i] = ($urandom % 4 == 0);
                end
            end
            #3;
            run_cycle(g);
            if (g >= 0) pend[g] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
